// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse generator: FSM state encoding and a
// bit-width helper used to size the timing and pending counters.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pg_state_e;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_generator_sat_counter.sv
// Saturating up/down counter holding the number of queued pulse requests.
// A simultaneous inc/dec is a no-op; an inc at MAX is dropped and flagged.
module sat_updown_counter
    import pulse_gen_pkg::*;
#(
    parameter int MAX = 3,
    parameter int W   = width_for(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         ovf_evt
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: saturate at both ends, paired inc/dec cancels.
    always_comb begin
        count_d = count_q;
        if (en && inc && !dec && (count_q != W'(MAX))) begin
            count_d = count_q + W'(1);
        end else if (en && dec && !inc && (count_q != W'(0))) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= W'(0);
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign full    = (count_q == W'(MAX));
    assign ovf_evt = en && inc && !dec && full;

endmodule

// File: rtl/pulse_generator.sv
// Converts single-cycle requests into registered pulses with fixed high width
// and minimum low gap; requests arriving while busy are queued and replayed.
// Optional feature macro: PULSE_GEN_TOGGLE_EN adds a toggle_out event line.
module pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter  int PULSE_CYC = 4,
    parameter  int GAP_CYC   = 2,
    parameter  int MAX_PEND  = 3,
    localparam int CNT_W     = width_for((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC),
    localparam int PEND_W    = width_for(MAX_PEND)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              pulse_req,
    input  logic              clear_ovf,
    output logic              data_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_count,
    output logic              overflow
`ifdef PULSE_GEN_TOGGLE_EN
    ,
    output logic              toggle_out
`endif
);

    pg_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              data_out_q, busy_q, overflow_q;
    logic              start_s, deq_s, inc_s;
    logic              pend_nz_s, pend_full_s, ovf_evt_s;
    logic [PEND_W-1:0] pend_s;

    assign pend_nz_s = (pend_s != PEND_W'(0));
    // Any request that does not start a pulse from an empty idle goes through the queue.
    assign inc_s     = enable && pulse_req && ((state_q != IDLE) || pend_nz_s);

    // Next-state and timing counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_s = 1'b0;
        deq_s   = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (pend_nz_s || pulse_req) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(PULSE_CYC);
                        start_s = 1'b1;
                        deq_s   = pend_nz_s;
                    end else begin
                        cnt_d   = CNT_W'(0);
                    end
                end
                HIGH: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(GAP_CYC);
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q != CNT_W'(1)) begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else if (pend_nz_s || pulse_req) begin
                        // A same-cycle request is enqueued and dequeued at once.
                        state_d = HIGH;
                        cnt_d   = CNT_W'(PULSE_CYC);
                        start_s = 1'b1;
                        deq_s   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = CNT_W'(0);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_W'(0);
                end
            endcase
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    sat_updown_counter #(
        .MAX (MAX_PEND),
        .W   (PEND_W)
    ) u_pend (
        .clk     (clk),
        .rst     (rst),
        .en      (enable),
        .inc     (inc_s),
        .dec     (deq_s),
        .count   (pend_s),
        .full    (pend_full_s),
        .ovf_evt (ovf_evt_s)
    );

    // FSM state, timing counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_W'(0);
            data_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (enable) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= (state_d == HIGH);
            busy_q     <= (state_d != IDLE);
        end
    end

    // Sticky overflow; a drop in the same cycle as clear_ovf keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (ovf_evt_s && pend_full_s) begin
            overflow_q <= 1'b1;
        end else if (clear_ovf) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef PULSE_GEN_TOGGLE_EN
    logic toggle_q;

    // Flip once per pulse start so a both-edge detector can count events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_q <= 1'b0;
        end else if (start_s) begin
            toggle_q <= ~toggle_q;
        end
    end

    assign toggle_out = toggle_q;
`else
    logic unused_start_s;
    assign unused_start_s = start_s;
`endif

    assign data_out   = data_out_q;
    assign busy       = busy_q;
    assign pend_count = pend_s;
    assign overflow   = overflow_q;

endmodule
